// File: rtl/stopwatch_core_if.sv
// -----------------------------------------------------------------------------
// stopwatch_core_if
//
// Purpose: groups the stopwatch's control inputs and display/status outputs
// into one bundle. The divider stage and button front-end drive it through
// the master modport, and stopwatch_core consumes it through the slave modport.
//
// Signals:
//   tick_clk        divided clock, one rising edge per 0.1 s (asynchronous)
//   start_stop_btn  raw level; a rising edge toggles run/pause
//   clear_btn       raw level; a rising edge zeroes the count and goes IDLE
//   lap_btn         raw level; a rising edge toggles lap hold (LAP_EN builds)
//   digit0..digit3  BCD display digits: tenths, seconds units, seconds tens,
//                   minutes
//   running         high in the RUN state
//   overflow        sticky wrap-around flag
//   lap_hold        high while the display is frozen
// -----------------------------------------------------------------------------
interface stopwatch_core_if;
    logic       tick_clk;
    logic       start_stop_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       running;
    logic       overflow;
    logic       lap_hold;

    modport master (
        output tick_clk, start_stop_btn, clear_btn, lap_btn,
        input  digit0, digit1, digit2, digit3, running, overflow, lap_hold
    );

    modport slave (
        input  tick_clk, start_stop_btn, clear_btn, lap_btn,
        output digit0, digit1, digit2, digit3, running, overflow, lap_hold
    );
endinterface

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//
// Purpose: tenths-of-a-second stopwatch (M:SS.t). The divided tick clock and
// the three buttons are synchronised into the clock_in domain and turned into
// single-cycle rising-edge pulses. A start/stop/clear state machine gates a
// four-digit BCD counter that wraps after MIN_MAX:59.9 and sets a sticky
// overflow flag.
//
// Configuration:
//   LAP_EN (macro) - when defined, a lap edge freezes the displayed digits
//                    while the internal count keeps running. When undefined,
//                    lap_btn is ignored, lap_hold is tied low and the digits
//                    always show the live count.
//
// Parameters:
//   MIN_MAX   highest minutes digit value (1..9), default 9
//
// Ports:
//   clock_in  system clock, the only clock in the block
//   reset_n   asynchronous, active-low reset
//   bus       stopwatch_core_if.slave: tick/button inputs, digit and status
//             outputs (all outputs registered)
// -----------------------------------------------------------------------------
module stopwatch_core #(
    parameter int unsigned MIN_MAX = 9
) (
    input  logic             clock_in,
    input  logic             reset_n,
    stopwatch_core_if.slave  bus
);

    localparam logic [3:0] MIN_DIGIT = 4'(MIN_MAX);

    // Bit positions of each synchronised input.
    localparam int TICK_BIT = 0;
    localparam int SS_BIT   = 1;
    localparam int CLR_BIT  = 2;

`ifdef LAP_EN
    localparam int LAP_BIT = 3;
    localparam int N_IN    = 4;
`else
    localparam int N_IN    = 3;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] d3;   // minutes
        logic [3:0] d2;   // seconds tens
        logic [3:0] d1;   // seconds units
        logic [3:0] d0;   // tenths
    } bcd_t;

    // -------------------------------------------------------------------------
    // Input synchronisers and edge detection
    // -------------------------------------------------------------------------
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync2_q;
    logic [N_IN-1:0] hist_q;
    logic [N_IN-1:0] edge_p;

`ifdef LAP_EN
    assign raw_in = {bus.lap_btn, bus.clear_btn, bus.start_stop_btn, bus.tick_clk};
`else
    assign raw_in = {bus.clear_btn, bus.start_stop_btn, bus.tick_clk};
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse
    // the two-stage synchroniser into a single stage.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // One-cycle pulse on each synchronised rising edge. A level already high
    // when reset releases still yields exactly one pulse.
    assign edge_p = sync2_q & ~hist_q;

    logic tick_p;
    logic ss_p;
    logic clr_p;
    assign tick_p = edge_p[TICK_BIT];
    assign ss_p   = edge_p[SS_BIT];
    assign clr_p  = edge_p[CLR_BIT];

    // -------------------------------------------------------------------------
    // Control FSM: state register
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next-state logic (clear beats start/stop)
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = IDLE;
        end else if (ss_p) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: output / datapath logic
    // -------------------------------------------------------------------------
    bcd_t cnt_q;
    bcd_t cnt_d;
    logic ovf_q;
    logic ovf_d;
    logic run_q;
    logic run_d;

    // A tick counts only in RUN and only when no clear arrives in the same
    // cycle. A start/stop edge in RUN does not suppress the tick: the count
    // advances and the FSM moves to PAUSE on the same edge.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        run_d = (state_d == RUN);
        if (clr_p) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (tick_p && (state_q == RUN)) begin
            if (cnt_q.d0 != 4'd9) begin
                cnt_d.d0 = cnt_q.d0 + 4'd1;
            end else begin
                cnt_d.d0 = 4'd0;
                if (cnt_q.d1 != 4'd9) begin
                    cnt_d.d1 = cnt_q.d1 + 4'd1;
                end else begin
                    cnt_d.d1 = 4'd0;
                    if (cnt_q.d2 != 4'd5) begin
                        cnt_d.d2 = cnt_q.d2 + 4'd1;
                    end else begin
                        cnt_d.d2 = 4'd0;
                        if (cnt_q.d3 != MIN_DIGIT) begin
                            cnt_d.d3 = cnt_q.d3 + 4'd1;
                        end else begin
                            // Full carry out of the minutes digit: wrap to
                            // zero and keep counting.
                            cnt_d.d3 = 4'd0;
                            ovf_d    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // NOTE: every flop in the block is reset, so the display, status outputs
    // and FSM return to a known zero state the instant reset_n falls.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            run_q <= run_d;
        end
    end

    assign bus.running  = run_q;
    assign bus.overflow = ovf_q;

    // -------------------------------------------------------------------------
    // Display path
    // -------------------------------------------------------------------------
`ifdef LAP_EN
    logic lap_p;
    logic hold_q;
    logic hold_d;
    bcd_t disp_q;
    bcd_t disp_d;

    assign lap_p = edge_p[LAP_BIT];

    // Lap toggles in RUN; in PAUSE it may only release; IDLE ignores it.
    // On set the display captures the count currently shown; while held it
    // stays frozen; otherwise it tracks the next count so that it equals
    // the live count from the following cycle on.
    always_comb begin
        hold_d = hold_q;
        if (clr_p) begin
            hold_d = 1'b0;
        end else if (lap_p) begin
            if (state_q == RUN) begin
                hold_d = ~hold_q;
            end else if (state_q == PAUSE) begin
                hold_d = 1'b0;
            end
        end

        if (hold_d) begin
            disp_d = hold_q ? disp_q : cnt_q;
        end else begin
            disp_d = cnt_d;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_d;
            disp_q <= disp_d;
        end
    end

    assign bus.digit0   = disp_q.d0;
    assign bus.digit1   = disp_q.d1;
    assign bus.digit2   = disp_q.d2;
    assign bus.digit3   = disp_q.d3;
    assign bus.lap_hold = hold_q;
`else
    assign bus.digit0   = cnt_q.d0;
    assign bus.digit1   = cnt_q.d1;
    assign bus.digit2   = cnt_q.d2;
    assign bus.digit3   = cnt_q.d3;
    assign bus.lap_hold = 1'b0;
`endif

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Tenths-of-a-second stopwatch that consumes the divided clock produced by the clock divider stage. The divided clock is sampled in the fast clock domain, its rising edges become single-cycle count enables, and a four-digit BCD counter (M:SS.t) advances under a start/stop/clear state machine. BCD outputs feed the seven-segment decode stage; an optional lap-hold feature freezes the displayed value while timing continues.

## Interface
- `MIN_MAX`, default 9: highest minutes digit value (1..9); the count wraps after `MIN_MAX`:59.9.
- `clock_in`  input  1  system clock; the only clock in the block.
- `reset_n`  input  1  asynchronous, active-low reset.
- `tick_clk`  input  1  divided clock from the divider stage, asynchronous to `clock_in`; one rising edge per 0.1 s.
- `start_stop_btn`  input  1  raw level; a rising edge toggles run/pause.
- `clear_btn`  input  1  raw level; a rising edge zeroes the count and returns the block to IDLE.
- `lap_btn`  input  1  raw level; a rising edge toggles lap hold (used only when `LAP_EN` is defined).
- `digit0`  output  4  tenths digit, BCD 0–9.
- `digit1`  output  4  seconds units digit, BCD 0–9.
- `digit2`  output  4  seconds tens digit, BCD 0–5.
- `digit3`  output  4  minutes digit, BCD 0–`MIN_MAX`.
- `running`  output  1  high in the RUN state.
- `overflow`  output  1  sticky; set on wrap-around.
- `lap_hold`  output  1  high while the display is frozen.

## Operation
- **Input synchronization.** `tick_clk`, `start_stop_btn`, `clear_btn` and `lap_btn` each pass through a 2-flop synchronizer followed by a history flop.
- **Edge pulses.** Each input yields a one-cycle edge pulse: `sync2 & ~hist`.
- **States.**
  - IDLE (reset state): count = 0, not counting.
  - RUN: counting.
  - PAUSE: count held.
- **Transitions.**
  - `start_stop` edge: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - `clear` edge: any state→IDLE.
- **Counting.** The count increments by 0.1 s only on a tick pulse while in RUN. Ticks in IDLE or PAUSE are discarded and not queued.
- **BCD carry chain.**
  - `digit0` runs 9→0 and carries into `digit1`.
  - `digit1` runs 9→0 and carries into `digit2`.
  - `digit2` runs 5→0 and carries into `digit3`.
  - `digit3` at `MIN_MAX` with a full carry wraps all digits to 0, sets `overflow`, and counting continues.
- **Overflow clear.** `overflow` clears only on a `clear` edge or on reset.
- **Simultaneous-event priority.** `clear` beats `start_stop`, which beats tick. A `clear` edge in the same cycle as a tick leaves the count at 0. A `start_stop` edge coincident with a tick in RUN means the tick is applied and the state becomes PAUSE in the same edge.
- **Clear effects.** A `clear` edge zeroes all digits, clears `overflow`, clears `lap_hold`, and sets the state to IDLE.
- **Reset.** Asserting `reset_n` low mid-count immediately forces:
  - all synchronizer and history flops to 0;
  - `digit0`–`digit3` to 0, `running` 0, `overflow` 0, `lap_hold` 0;
  - state IDLE.
- **Post-reset inputs.** A button already held high when reset releases produces an edge pulse 2 cycles later; this is intentional, and a held button counts as one press.

## Timing
- All state changes occur on the `posedge clock_in`.
- **Tick latency.**
  - `tick_clk` first sampled high at edge N.
  - `sync2` is high after edge N+1, so the pulse is high during the cycle after edge N+1.
  - The count updates at edge N+2.
- **Button latency.** Same as tick: the state changes at the third `clock_in` edge after the input rises.
- **Output registering.** The digits, `running`, `overflow` and `lap_hold` outputs are registered; there is no combinational path from inputs to outputs.
- **Pulse width.** Edge pulses are exactly one `clock_in` cycle wide.
- **Minimum input widths.**
  - `tick_clk` high and low phases must each be ≥ 3 `clock_in` cycles for an edge to be guaranteed seen.
  - A button must be high ≥ 3 cycles.
  - Bounce is not filtered here; debouncing belongs to the upstream stage.

## Configuration
- **`LAP_EN` defined:**
  - A `lap` edge in RUN toggles `lap_hold`.
  - On set, `digit0`–`digit3` capture the live count and stay frozen while the internal count keeps advancing.
  - On release, the digits show the live count starting the next cycle.
  - A `lap` edge in PAUSE may only release a hold.
  - `lap` edges in IDLE are ignored.
- **`LAP_EN` undefined:**
  - `lap_btn` is ignored and no lap logic is synthesized.
  - `lap_hold` is tied to 0.
  - The digits always show the live count.

## Test plan
- **Reset mid-run.** Reset asserted at count 1:23.4 in RUN -> digits 0,0,0,0, `running`=0, `overflow`=0 immediately, without waiting for a clock edge.
- **Basic run.** From IDLE: one `start_stop` edge, then 12 `tick_clk` rising edges -> digits read 0:01.2, `running`=1. Each update lands at the third `clock_in` edge after the tick rises.
- **Pause.** `start_stop` edge in RUN at 0:05.7, then 20 ticks -> count stays 0:05.7. A further `start_stop` edge plus 3 ticks -> 0:06.0, with carry into `digit1` verified.
- **Wrap.** With `MIN_MAX`=1, run from 1:59.8 for 2 ticks -> 1:59.9 then 0:00.0, `overflow`=1 and still running. A `clear` edge -> 0:00.0, `overflow`=0, state IDLE.
- **Simultaneous events.** `clear` edge and tick pulse in the same cycle at 0:30.0 -> count 0:00.0, IDLE.
- **Lap hold (`LAP_EN` defined).** `lap` edge at 0:10.0, then 15 ticks -> digits hold 0:10.0 while the internal count reaches 0:11.5. A second `lap` edge -> digits show 0:11.5 on the next cycle.
